pipe_ifid_reg: RTL and testbench

IF/ID pipeline register for the 5-stage pipelined CPU. It sits directly downstream of the PC register and instruction memory, and feeds the decode stage. It latches pc, pc+4 and the fetched instruction, and honours the decode-stage stall (wpcir) and the branch/jump flush. It absorbs the PC register's post-reset double fetch of address 0 through a warm-up state, tracks a valid bit, and keeps fetch performance counters.

---
 rtl/pipe_ifid_reg_pkg.sv | 12 +
 rtl/pipe_perf_cnt.sv | 27 ++
 rtl/pipe_ifid_reg.sv | 109 ++++++++++
 tb/tb_pipe_ifid_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ifid_reg_pkg.sv
// Shared CPU pipeline definitions: datapath width, bubble instruction and IF/ID warm-up states.
package pipe_ifid_reg_pkg;

    localparam int          DEF_WIDTH   = 32;
    localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

    typedef enum logic {
        ST_WARM = 1'b0,
        ST_RUN  = 1'b1
    } ifid_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running wrap counter; increments by one on each cycle inc_i is high, 1-cycle update.
// No backpressure; wraps to zero after the all-ones value.
module pipe_perf_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = inc_i ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ifid_reg.sv
// IF/ID pipeline register: 1-cycle latency, holds on wpcir=0, squashes on flush, bubbles when imem not ready.
// A one-edge warm-up state absorbs the PC register's duplicate fetch of address 0 after reset.
module pipe_ifid_reg
    import pipe_ifid_reg_pkg::*;
#(
    parameter int               WIDTH   = DEF_WIDTH,
    parameter int               CNT_W   = 16,
    parameter logic [WIDTH-1:0] NOP_INS = WIDTH'(NOP_INS_DEF)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc4,
    input  logic [WIDTH-1:0] ins,
    input  logic             ivalid,
    input  logic             wpcir,
    input  logic             flush,
    output logic [WIDTH-1:0] dpc,
    output logic [WIDTH-1:0] dpc4,
    output logic [WIDTH-1:0] dins,
    output logic             dvalid,
    output logic             fstall,
    output logic [CNT_W-1:0] cnt_fetch,
    output logic [CNT_W-1:0] cnt_bubble,
    output logic [CNT_W-1:0] cnt_stall
);

    ifid_state_e      state_q, state_d;
    logic [WIDTH-1:0] dpc_q, dpc_d;
    logic [WIDTH-1:0] dpc4_q, dpc4_d;
    logic [WIDTH-1:0] dins_q, dins_d;
    logic             dvalid_q, dvalid_d;
    logic             inc_fetch, inc_bubble, inc_stall;

    always_comb begin
        state_d    = ST_RUN;
        dpc_d      = dpc_q;
        dpc4_d     = dpc4_q;
        dins_d     = dins_q;
        dvalid_d   = dvalid_q;
        inc_fetch  = 1'b0;
        inc_bubble = 1'b0;
        inc_stall  = 1'b0;
        if (state_q == ST_RUN) begin
            // Priority: flush beats stall, stall beats imem-not-ready.
            if (flush) begin
                dins_d     = NOP_INS;
                dvalid_d   = 1'b0;
                inc_bubble = 1'b1;
            end else if (!wpcir) begin
                inc_stall  = 1'b1;
            end else if (!ivalid) begin
                dins_d     = NOP_INS;
                dvalid_d   = 1'b0;
                inc_bubble = 1'b1;
            end else begin
                dpc_d      = pc;
                dpc4_d     = pc4;
                dins_d     = ins;
                dvalid_d   = 1'b1;
                inc_fetch  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_WARM;
            dpc_q    <= '0;
            dpc4_q   <= '0;
            dins_q   <= NOP_INS;
            dvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dpc_q    <= dpc_d;
            dpc4_q   <= dpc4_d;
            dins_q   <= dins_d;
            dvalid_q <= dvalid_d;
        end
    end

    assign dpc    = dpc_q;
    assign dpc4   = dpc4_q;
    assign dins   = dins_q;
    assign dvalid = dvalid_q;
    assign fstall = (state_q == ST_RUN) && !ivalid;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_fetch (
        .clk_i  (clock),
        .rst_ni (resetn),
        .inc_i  (inc_fetch),
        .cnt_o  (cnt_fetch)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_bubble (
        .clk_i  (clock),
        .rst_ni (resetn),
        .inc_i  (inc_bubble),
        .cnt_o  (cnt_bubble)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk_i  (clock),
        .rst_ni (resetn),
        .inc_i  (inc_stall),
        .cnt_o  (cnt_stall)
    );

endmodule

// File: tb/tb_pipe_ifid_reg.sv
// Scoreboarded bench for pipe_ifid_reg with 4-bit counters so wrap-around is reached quickly.
module tb_pipe_ifid_reg;

    localparam int W  = 32;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          resetn;
    logic [W-1:0]  pc, pc4, ins;
    logic          ivalid, wpcir, flush;
    logic [W-1:0]  dpc, dpc4, dins;
    logic          dvalid, fstall;
    logic [CW-1:0] cnt_fetch, cnt_bubble, cnt_stall;

    pipe_ifid_reg #(.WIDTH(W), .CNT_W(CW), .NOP_INS(32'h0000_0000)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .pc         (pc),
        .pc4        (pc4),
        .ins        (ins),
        .ivalid     (ivalid),
        .wpcir      (wpcir),
        .flush      (flush),
        .dpc        (dpc),
        .dpc4       (dpc4),
        .dins       (dins),
        .dvalid     (dvalid),
        .fstall     (fstall),
        .cnt_fetch  (cnt_fetch),
        .cnt_bubble (cnt_bubble),
        .cnt_stall  (cnt_stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] dpc;
        logic [W-1:0] dpc4;
        logic [W-1:0] dins;
        logic         dvalid;
        int           cf;
        int           cb;
        int           cs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: architectural view of what ID should see after the next edge.
    bit           m_run;
    logic [W-1:0] m_dpc, m_dpc4, m_dins;
    logic         m_dvalid;
    int           m_cf, m_cb, m_cs;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run = 0; m_dpc = '0; m_dpc4 = '0; m_dins = '0; m_dvalid = 0;
        m_cf = 0; m_cb = 0; m_cs = 0;
    endtask

    task automatic model_step_and_push();
        exp_t e;
        if (!m_run) begin
            m_run = 1;
        end else if (flush) begin
            m_dins = '0; m_dvalid = 0; m_cb = (m_cb + 1) % 16;
        end else if (!wpcir) begin
            m_cs = (m_cs + 1) % 16;
        end else if (!ivalid) begin
            m_dins = '0; m_dvalid = 0; m_cb = (m_cb + 1) % 16;
        end else begin
            m_dpc = pc; m_dpc4 = pc4; m_dins = ins; m_dvalid = 1;
            m_cf = (m_cf + 1) % 16;
        end
        e.dpc = m_dpc; e.dpc4 = m_dpc4; e.dins = m_dins; e.dvalid = m_dvalid;
        e.cf = m_cf; e.cb = m_cb; e.cs = m_cs;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] p, input logic [W-1:0] i,
                         input logic iv, input logic wp, input logic fl);
        @(negedge clock);
        pc = p; pc4 = p + 32'd4; ins = i; ivalid = iv; wpcir = wp; flush = fl;
        #1;
        check("fstall", {31'd0, fstall}, {31'd0, (m_run && !iv)});
        model_step_and_push();
    endtask

    // Asynchronous reset pulse between edges; the following edge is the warm-up edge.
    task automatic do_reset();
        @(negedge clock);
        pc = $urandom; pc4 = pc + 32'd4; ins = $urandom;
        ivalid = 1'b1; wpcir = 1'b1; flush = 1'b0;
        #2 resetn = 1'b0;
        #1;
        check("rst_dpc", dpc, '0);
        check("rst_dpc4", dpc4, '0);
        check("rst_dins", dins, '0);
        check("rst_dvalid", {31'd0, dvalid}, '0);
        check("rst_cnt_fetch", {28'd0, cnt_fetch}, '0);
        check("rst_cnt_bubble", {28'd0, cnt_bubble}, '0);
        check("rst_cnt_stall", {28'd0, cnt_stall}, '0);
        resetn = 1'b1;
        ivalid = 1'b0;
        #1;
        check("warm_fstall", {31'd0, fstall}, '0);
        ivalid = 1'b1;
        model_clear();
        model_step_and_push();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dpc", dpc, e.dpc);
                check("dpc4", dpc4, e.dpc4);
                check("dins", dins, e.dins);
                check("dvalid", {31'd0, dvalid}, {31'd0, e.dvalid});
                check("cnt_fetch", {28'd0, cnt_fetch}, W'(e.cf));
                check("cnt_bubble", {28'd0, cnt_bubble}, W'(e.cb));
                check("cnt_stall", {28'd0, cnt_stall}, W'(e.cs));
            end
        end
    end

    initial begin : stimulus
        logic [W-1:0] p;
        resetn = 1'b0;
        pc = '0; pc4 = 32'd4; ins = '0; ivalid = 1'b1; wpcir = 1'b1; flush = 1'b0;
        model_clear();
        do_reset();

        // Post-reset fetch of 0, then 4.
        drive(32'h0, 32'hA000_0000, 1, 1, 0);
        drive(32'h4, 32'hA000_0004, 1, 1, 0);
        // Three decode stalls with pc=0x10 waiting, then advance.
        repeat (3) drive(32'h10, 32'hA000_0010, 1, 0, 0);
        drive(32'h10, 32'hA000_0010, 1, 1, 0);
        // Flush together with stall.
        drive(32'h14, 32'hA000_0014, 1, 0, 1);
        // Imem not ready.
        drive(32'h18, 32'hA000_0018, 0, 1, 0);
        drive(32'h18, 32'hA000_0018, 1, 1, 0);
        // Sixteen fetches wrap the 4-bit fetch counter.
        for (int k = 0; k < 16; k++) drive(32'h100 + 32'(k * 4), $urandom, 1, 1, 0);
        // Mid-stream reset.
        do_reset();
        drive(32'h0, 32'hB000_0000, 1, 1, 0);

        p = 32'h200;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive(p, $urandom, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 7) == 0));
                p = p + 32'd4;
            end
        end

        repeat (3) @(negedge clock);
        check("queue_drained", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
